// File: rtl/pipelined_mips_core.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_mips_core
//  Purpose  : 5-stage (IF/ID/EX/MEM/WB) pipelined core with eight DW-bit
//             registers, carry/zero flags, full EX forwarding, a one-cycle
//             load-use interlock and branch/jump resolution in ID.
//  Ports    : clk        - clock, all state on the rising edge
//             reset      - asynchronous active-low reset
//             imem_addr  - current PC (instruction fetch address)
//             imem_data  - 19-bit instruction at imem_addr (combinational)
//             dmem_addr  - address of the MEM-stage instruction
//             dmem_wdata - store data
//             dmem_we    - write strobe, high only for a ST in MEM
//             dmem_rdata - combinational read data of dmem_addr
//  Revision : 1.0 - initial release
// ============================================================================
module pipelined_mips_core #(
    parameter int PC_W = 12,
    parameter int DW   = 8
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    input  logic [18:0]     imem_data,
    output logic [DW-1:0]   dmem_addr,
    output logic [DW-1:0]   dmem_wdata,
    output logic            dmem_we,
    input  logic [DW-1:0]   dmem_rdata
);

    localparam logic [18:0] c_nop = 19'h7FFFF;

    // ------------------------------------------------------------------ state
    logic [PC_W-1:0] pc_q, pc_d;
    logic [18:0]     ifid_instr_q, ifid_instr_d;
    logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
    logic [18:0]     idex_instr_q, idex_instr_d;
    logic [DW-1:0]   idex_a_q, idex_a_d, idex_b_q, idex_b_d, idex_s_q, idex_s_d;
    logic [18:0]     exmem_instr_q, exmem_instr_d;
    logic [DW-1:0]   exmem_res_q, exmem_res_d, exmem_sd_q, exmem_sd_d;
    logic [18:0]     memwb_instr_q, memwb_instr_d;
    logic [DW-1:0]   memwb_val_q, memwb_val_d;
    logic [DW-1:0]   rf_q [8];
    logic [DW-1:0]   rf_d [8];
    logic            carry_q, carry_d, zero_q, zero_d;

    // --------------------------------------------------------------- WB stage
    logic       wb_en;
    logic [2:0] wb_rd;
    assign wb_en = ~memwb_instr_q[18] | (memwb_instr_q[18:16] == 3'b100);
    assign wb_rd = memwb_instr_q[13:11];

    // MEM/WB fields that write-back never looks at
    logic unused_wb_bits;
    assign unused_wb_bits = ^{memwb_instr_q[15:14], memwb_instr_q[10:0]};

    // --------------------------------------------------------------- ID stage
    logic [18:0] id_i;
    logic        id_rd_rs, id_rd_rt, id_rd_sd, id_is_br, id_is_jmp;
    assign id_i      = ifid_instr_q;
    assign id_rd_rs  = ~id_i[18] | (id_i[18:17] == 2'b10);
    assign id_rd_rt  = (id_i[18:17] == 2'b00);
    assign id_rd_sd  = (id_i[18:16] == 3'b101);
    assign id_is_br  = (id_i[18:16] == 3'b110);
    assign id_is_jmp = (id_i[18:15] == 4'b1110);

    // Register reads see a write-back happening in the same cycle
    logic [DW-1:0] id_a, id_b, id_s;
    assign id_a = (wb_en && wb_rd == id_i[10:8])  ? memwb_val_q : rf_q[id_i[10:8]];
    assign id_b = (wb_en && wb_rd == id_i[7:5])   ? memwb_val_q : rf_q[id_i[7:5]];
    assign id_s = (wb_en && wb_rd == id_i[13:11]) ? memwb_val_q : rf_q[id_i[13:11]];

    // --------------------------------------------------------------- EX stage
    logic [18:0] ex_i;
    logic        ex_alu, ex_ld, ex_wr_c, ex_rtype, mem_alu, mem_ld;
    assign ex_i     = idex_instr_q;
    assign ex_alu   = ~ex_i[18];
    assign ex_ld    = (ex_i[18:16] == 3'b100);
    assign ex_wr_c  = ex_alu & ~ex_i[16];
    assign ex_rtype = (ex_i[18:17] == 2'b00);
    assign mem_alu  = ~exmem_instr_q[18];
    assign mem_ld   = (exmem_instr_q[18:16] == 3'b100);

    // Forwarding: later assignment wins, so EX/MEM outranks MEM/WB.
    // A load in EX/MEM never needs forwarding here thanks to the interlock.
    logic [DW-1:0] fwd_a, fwd_b, fwd_s;
    always_comb begin
        fwd_a = idex_a_q;
        fwd_b = idex_b_q;
        fwd_s = idex_s_q;
        if (wb_en && wb_rd == ex_i[10:8])  fwd_a = memwb_val_q;
        if (wb_en && wb_rd == ex_i[7:5])   fwd_b = memwb_val_q;
        if (wb_en && wb_rd == ex_i[13:11]) fwd_s = memwb_val_q;
        if (mem_alu && exmem_instr_q[13:11] == ex_i[10:8])  fwd_a = exmem_res_q;
        if (mem_alu && exmem_instr_q[13:11] == ex_i[7:5])   fwd_b = exmem_res_q;
        if (mem_alu && exmem_instr_q[13:11] == ex_i[13:11]) fwd_s = exmem_res_q;
    end

    logic [DW-1:0] op_b, ex_addr, ex_res;
    logic [DW:0]   ex_sum;
    logic [DW:0]   cin;
    logic          ex_c, ex_z;
    assign op_b    = ex_rtype ? fwd_b : DW'(ex_i[7:0]);
    assign ex_addr = fwd_a + DW'(ex_i[7:0]);
    assign cin     = {{DW{1'b0}}, carry_q};

    // The extra MSB carries out on add and goes high on borrow for subtract
    always_comb begin
        ex_sum = '0;
        case (ex_i[16:14])
            3'b000:  ex_sum = {1'b0, fwd_a} + {1'b0, op_b};
            3'b001:  ex_sum = {1'b0, fwd_a} + {1'b0, op_b} + cin;
            3'b010:  ex_sum = {1'b0, fwd_a} - {1'b0, op_b};
            3'b011:  ex_sum = {1'b0, fwd_a} - {1'b0, op_b} - cin;
            3'b100:  ex_sum = {1'b0, fwd_a & op_b};
            3'b101:  ex_sum = {1'b0, fwd_a | op_b};
            3'b110:  ex_sum = {1'b0, fwd_a ^ op_b};
            default: ex_sum = {1'b0, op_b};
        endcase
    end
    assign ex_res = ex_alu ? ex_sum[DW-1:0] : ex_addr;
    assign ex_c   = ex_sum[DW];
    assign ex_z   = (ex_sum[DW-1:0] == '0);

    // ------------------------------------------------ hazard and branch logic
    logic stall;
    assign stall = ex_ld & ((id_rd_rs && ex_i[13:11] == id_i[10:8]) ||
                            (id_rd_rt && ex_i[13:11] == id_i[7:5])  ||
                            (id_rd_sd && ex_i[13:11] == id_i[13:11]));

    // Branches see the flags the EX instruction is about to commit
    logic br_z, br_c, br_taken, id_jump;
    assign br_z = ex_alu  ? ex_z : zero_q;
    assign br_c = ex_wr_c ? ex_c : carry_q;
    always_comb begin
        br_taken = 1'b0;
        case (id_i[15:14])
            2'b00:   br_taken = br_z;
            2'b01:   br_taken = ~br_z;
            2'b10:   br_taken = br_c;
            default: br_taken = ~br_c;
        endcase
    end
    assign id_jump = id_is_jmp | (id_is_br & br_taken);

    logic [PC_W-1:0] id_target;
    assign id_target = id_is_jmp ? PC_W'(id_i[11:0])
                     : ifid_pc_q + PC_W'(1) + {{(PC_W-8){id_i[7]}}, id_i[7:0]};

    // ------------------------------------------------------------- next state
    always_comb begin
        pc_d         = pc_q + PC_W'(1);
        ifid_instr_d = imem_data;
        ifid_pc_d    = pc_q;
        idex_instr_d = id_i;
        idex_a_d     = id_a;
        idex_b_d     = id_b;
        idex_s_d     = id_s;
        if (stall) begin
            pc_d         = pc_q;
            ifid_instr_d = ifid_instr_q;
            ifid_pc_d    = ifid_pc_q;
            idex_instr_d = c_nop;
        end else if (id_jump) begin
            pc_d         = id_target;
            ifid_instr_d = c_nop;
        end
        exmem_instr_d = ex_i;
        exmem_res_d   = ex_res;
        exmem_sd_d    = fwd_s;
        memwb_instr_d = exmem_instr_q;
        memwb_val_d   = mem_ld ? dmem_rdata : exmem_res_q;
        carry_d       = ex_wr_c ? ex_c : carry_q;
        zero_d        = ex_alu  ? ex_z : zero_q;
        for (int k = 0; k < 8; k++) rf_d[k] = rf_q[k];
        if (wb_en) rf_d[wb_rd] = memwb_val_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= '0;
            ifid_instr_q  <= c_nop;
            ifid_pc_q     <= '0;
            idex_instr_q  <= c_nop;
            idex_a_q      <= '0;
            idex_b_q      <= '0;
            idex_s_q      <= '0;
            exmem_instr_q <= c_nop;
            exmem_res_q   <= '0;
            exmem_sd_q    <= '0;
            memwb_instr_q <= c_nop;
            memwb_val_q   <= '0;
            carry_q       <= 1'b0;
            zero_q        <= 1'b0;
            for (int k = 0; k < 8; k++) rf_q[k] <= '0;
        end else begin
            pc_q          <= pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc_q     <= ifid_pc_d;
            idex_instr_q  <= idex_instr_d;
            idex_a_q      <= idex_a_d;
            idex_b_q      <= idex_b_d;
            idex_s_q      <= idex_s_d;
            exmem_instr_q <= exmem_instr_d;
            exmem_res_q   <= exmem_res_d;
            exmem_sd_q    <= exmem_sd_d;
            memwb_instr_q <= memwb_instr_d;
            memwb_val_q   <= memwb_val_d;
            carry_q       <= carry_d;
            zero_q        <= zero_d;
            for (int k = 0; k < 8; k++) rf_q[k] <= rf_d[k];
        end
    end

    // ---------------------------------------------------------------- outputs
    assign imem_addr  = pc_q;
    assign dmem_addr  = exmem_res_q;
    assign dmem_wdata = exmem_sd_q;
    assign dmem_we    = (exmem_instr_q[18:16] == 3'b101);

endmodule
`default_nettype wire

// File: tb/tb_pipelined_mips_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_mips_core
//  Purpose  : Self-checking bench for pipelined_mips_core: directed programs
//             for reset, forwarding, load-use, flags/branch, carry chain and
//             mid-run reset, plus random programs compared against an
//             instruction-level architectural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_mips_core;

    localparam int PC_W = 12;
    localparam int DW   = 8;
    localparam logic [18:0] c_nop = 19'h7FFFF;
    localparam int BODY = 40;

    logic            clk = 1'b0;
    logic            reset;
    logic [PC_W-1:0] imem_addr;
    logic [18:0]     imem_data;
    logic [DW-1:0]   dmem_addr, dmem_wdata, dmem_rdata;
    logic            dmem_we;

    logic [18:0] prog [4096];
    logic [7:0]  dmem [256];

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int wq_cyc[$], wq_addr[$], wq_data[$];
    int ea[$], ed[$];

    always #5 clk = ~clk;

    assign imem_data  = prog[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    pipelined_mips_core #(.PC_W(PC_W), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_rdata (dmem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------- encoders
    function automatic logic [18:0] enc_r(int op, int rd, int rs, int rt);
        return {2'b00, 3'(op), 3'(rd), 3'(rs), 3'(rt), 5'b0};
    endfunction
    function automatic logic [18:0] enc_i(int op, int rd, int rs, int imm);
        return {2'b01, 3'(op), 3'(rd), 3'(rs), 8'(imm)};
    endfunction
    function automatic logic [18:0] enc_ld(int rd, int rs, int imm);
        return {3'b100, 2'b00, 3'(rd), 3'(rs), 8'(imm)};
    endfunction
    function automatic logic [18:0] enc_st(int rsrc, int rs, int imm);
        return {3'b101, 2'b00, 3'(rsrc), 3'(rs), 8'(imm)};
    endfunction
    function automatic logic [18:0] enc_br(int cond, int imm);
        return {3'b110, 2'(cond), 6'b0, 8'(imm)};
    endfunction
    function automatic logic [18:0] enc_jmp(int t);
        return {4'b1110, 3'b000, 12'(t)};
    endfunction

    task automatic clear_prog();
        for (int k = 0; k < 4096; k++) prog[k] = c_nop;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
    endtask

    // Memory writes land at the sampling point of the cycle whose ST is in
    // MEM; no load can read that location before the following edge.
    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (dmem_we) begin
                wq_cyc.push_back(cyc);
                wq_addr.push_back(int'(dmem_addr));
                wq_data.push_back(int'(dmem_wdata));
                dmem[dmem_addr] = dmem_wdata;
            end
        end
    endtask

    task automatic clear_q();
        wq_cyc.delete();
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic run_directed(input string name, input int ecyc, input int eaddr, input int edata);
        do_reset();
        clear_q();
        run_cycles(20);
        check({name, "_nwrites"}, wq_cyc.size(), 1);
        if (wq_cyc.size() >= 1) begin
            check({name, "_cycle"}, wq_cyc[0], ecyc);
            check({name, "_addr"},  wq_addr[0], eaddr);
            check({name, "_data"},  wq_data[0], edata);
        end
    endtask

    // ------------------------------------------- architectural reference
    task automatic model_run(input int end_pc);
        int r[8];
        int mm[256];
        int pc, npc, steps, c, z, a, b, s, addr, off, cond, rd, rs, rt;
        logic [18:0] ins;
        for (int k = 0; k < 8; k++) r[k] = 0;
        for (int k = 0; k < 256; k++) mm[k] = int'(dmem[k]);
        pc = 0; c = 0; z = 0; steps = 0;
        ea.delete();
        ed.delete();
        while (pc < end_pc && steps < 1000) begin
            ins = prog[pc];
            rd = int'(ins[13:11]); rs = int'(ins[10:8]); rt = int'(ins[7:5]);
            npc = pc + 1;
            steps++;
            if (ins[18] == 1'b0) begin
                a = r[rs];
                b = ins[17] ? int'(ins[7:0]) : r[rt];
                case (int'(ins[16:14]))
                    0: begin s = a + b;     c = (s > 255) ? 1 : 0; end
                    1: begin s = a + b + c; c = (s > 255) ? 1 : 0; end
                    2: begin s = a - b;     c = (s < 0) ? 1 : 0;   end
                    3: begin s = a - b - c; c = (s < 0) ? 1 : 0;   end
                    4: s = a & b;
                    5: s = a | b;
                    6: s = a ^ b;
                    default: s = b;
                endcase
                r[rd] = s & 255;
                z = (r[rd] == 0) ? 1 : 0;
            end else if (ins[18:16] == 3'b100) begin
                addr = (r[rs] + int'(ins[7:0])) & 255;
                r[rd] = mm[addr];
            end else if (ins[18:16] == 3'b101) begin
                addr = (r[rs] + int'(ins[7:0])) & 255;
                ea.push_back(addr);
                ed.push_back(r[rd]);
                mm[addr] = r[rd];
            end else if (ins[18:16] == 3'b110) begin
                cond = int'(ins[15:14]);
                off = int'(ins[7:0]);
                if (off > 127) off = off - 256;
                if ((cond == 0 && z == 1) || (cond == 1 && z == 0) ||
                    (cond == 2 && c == 1) || (cond == 3 && c == 0))
                    npc = pc + 1 + off;
            end else if (ins[18:15] == 4'b1110) begin
                npc = int'(ins[11:0]);
            end
            pc = npc % 4096;
        end
    endtask

    task automatic gen_prog();
        int sel;
        clear_prog();
        for (int p = 0; p < BODY; p++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 35)
                prog[p] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            else if (sel < 60)
                prog[p] = enc_i($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
            else if (sel < 70)
                prog[p] = enc_ld($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
            else if (sel < 82)
                prog[p] = enc_st($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
            else if (sel < 92)
                prog[p] = enc_br($urandom_range(0, 3), $urandom_range(0, 3));
            else if (sel < 96)
                prog[p] = enc_jmp(p + 1 + int'($urandom_range(0, 3)));
            else
                prog[p] = c_nop;
        end
        for (int k = 0; k < 8; k++) prog[BODY + k] = enc_st(k, 0, 8'hF0 + k);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        cyc = 0;
        clear_prog();
        for (int k = 0; k < 256; k++) dmem[k] = 8'h00;

        // Reset behaviour and PC sequencing over NOPs
        @(negedge clk);
        @(negedge clk);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_dmem_we", dmem_we, 0);
        reset = 1'b1;
        #1;
        check("rel_pc0", imem_addr, 0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rel_pc%0d", k), imem_addr, k);
        end
        clear_q();
        run_cycles(10);
        check("nop_no_writes", wq_cyc.size(), 0);

        // Forwarding chain, no stall
        clear_prog();
        prog[0] = enc_i(0, 1, 0, 5);
        prog[1] = enc_i(0, 2, 1, 3);
        prog[2] = enc_r(0, 3, 2, 1);
        prog[3] = enc_st(3, 0, 8'h10);
        run_directed("fwd", 6, 8'h10, 8'h0D);

        // Load-use: one stall cycle
        clear_prog();
        dmem[8'h20] = 8'h7F;
        prog[0] = enc_ld(1, 0, 8'h20);
        prog[1] = enc_i(0, 2, 1, 1);
        prog[2] = enc_st(2, 0, 8'h21);
        run_directed("ldu", 6, 8'h21, 8'h80);

        // Carry/zero forwarded into a taken BC
        clear_prog();
        prog[0] = enc_i(0, 1, 0, 8'hFF);
        prog[1] = enc_i(0, 1, 1, 1);
        prog[2] = enc_br(2, 1);
        prog[3] = enc_st(1, 0, 1);
        prog[4] = enc_st(1, 0, 2);
        run_directed("bc", 7, 2, 0);

        // Carry chain into ADC, with a not-taken BNC in the stream
        clear_prog();
        prog[0] = enc_i(0, 1, 0, 8'hF0);
        prog[1] = enc_i(0, 1, 1, 8'h20);
        prog[2] = enc_br(3, 3);
        prog[3] = enc_r(1, 2, 0, 0);
        prog[4] = enc_st(2, 0, 3);
        run_directed("adc", 7, 3, 1);

        // Mid-run reset while the store is in EX
        clear_prog();
        prog[0] = enc_i(0, 1, 0, 5);
        prog[1] = enc_i(0, 2, 1, 3);
        prog[2] = enc_r(0, 3, 2, 1);
        prog[3] = enc_st(3, 0, 8'h10);
        dmem[8'h10] = 8'hAA;
        do_reset();
        clear_q();
        run_cycles(5);
        reset = 1'b0;
        #1;
        check("midrst_pc", imem_addr, 0);
        check("midrst_we", dmem_we, 0);
        run_cycles(3);
        check("midrst_no_writes", wq_cyc.size(), 0);
        check("midrst_mem_kept", dmem[8'h10], 8'hAA);
        run_directed("restart", 6, 8'h10, 8'h0D);

        // Random programs against the architectural model
        for (int it = 0; it < 20; it++) begin
            gen_prog();
            for (int k = 0; k < 256; k++) dmem[k] = 8'($urandom_range(0, 255));
            model_run(BODY + 8);
            do_reset();
            clear_q();
            run_cycles(140);
            check($sformatf("rnd%0d_nwrites", it), wq_addr.size(), ea.size());
            for (int i = 0; i < wq_addr.size() && i < ea.size(); i++) begin
                check($sformatf("rnd%0d_addr%0d", it, i), wq_addr[i], ea[i]);
                check($sformatf("rnd%0d_data%0d", it, i), wq_data[i], ed[i]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
